// File: rtl/chain_test_ctrl.sv
// chain_test_ctrl: flush/prime/check sequencer for a CHAIN_LEN-stage delay-chain test structure.
// Compares chain output against a regenerated pattern and reports pass, error count and first failing index.
module chain_test_ctrl #(
    parameter int CHAIN_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] num_bits,
    output logic             chain_din,
    input  logic             chain_dout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx
);
    typedef enum logic [2:0] {IDLE, FLUSH, PRIME, CHECK, DONE} state_t;
    localparam int CW = (CNT_W > $clog2(CHAIN_LEN)) ? CNT_W : $clog2(CHAIN_LEN);
    localparam logic [7:0] SEED = 8'hA5;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;
    logic [CNT_W-1:0] nb_q, nb_d, err_q, err_d, first_q, first_d;
    logic pass_q, pass_d;
    logic [7:0] src_lfsr_q, src_lfsr_d, exp_lfsr_q, exp_lfsr_d;
    logic src_alt_q, src_alt_d, exp_alt_q, exp_alt_d;
    logic last_stage, streaming, go, mismatch, src_bit, exp_bit;

    function automatic logic pat_bit(input logic [1:0] m, input logic b7, input logic a);
        return m == 2'd0 ? 1'b0 : m == 2'd1 ? 1'b1 : m == 2'd2 ? a : b7;
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mode_q     <= '0;
            nb_q       <= '0;
            err_q      <= '0;
            first_q    <= '0;
            pass_q     <= 1'b0;
            src_lfsr_q <= SEED;
            exp_lfsr_q <= SEED;
            src_alt_q  <= 1'b1;
            exp_alt_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            nb_q       <= nb_d;
            err_q      <= err_d;
            first_q    <= first_d;
            pass_q     <= pass_d;
            src_lfsr_q <= src_lfsr_d;
            exp_lfsr_q <= exp_lfsr_d;
            src_alt_q  <= src_alt_d;
            exp_alt_q  <= exp_alt_d;
        end
    end

    assign last_stage = cnt_q == CW'(CHAIN_LEN - 1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = (start && !abort) ? FLUSH : IDLE;
            FLUSH:   state_d = abort ? IDLE : last_stage ? PRIME : FLUSH;
            PRIME:   state_d = abort ? IDLE : !last_stage ? PRIME : (nb_q == '0) ? DONE : CHECK;
            CHECK:   state_d = abort ? IDLE : (cnt_q + 1'b1 == CW'(nb_q)) ? DONE : CHECK;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Source runs through PRIME and CHECK; the expected copy restarts from seed on CHECK entry.
    always_comb begin
        streaming  = state_q == PRIME || state_q == CHECK;
        go         = state_q == IDLE && start && !abort;
        src_bit    = pat_bit(mode_q, src_lfsr_q[7], src_alt_q);
        exp_bit    = pat_bit(mode_q, exp_lfsr_q[7], exp_alt_q);
        mismatch   = state_q == CHECK && !abort && chain_dout != exp_bit;
        cnt_d      = (state_d != state_q || state_q == IDLE) ? '0 : cnt_q + 1'b1;
        mode_d     = go ? mode : mode_q;
        nb_d       = go ? num_bits : nb_q;
        err_d      = go ? '0 : err_q + CNT_W'(mismatch);
        first_d    = go ? '0 : (mismatch && err_q == '0) ? CNT_W'(cnt_q) : first_q;
        pass_d     = (go || (busy && abort)) ? 1'b0 : (state_d == DONE) ? (err_d == '0) : pass_q;
        src_lfsr_d = streaming ? lfsr_step(src_lfsr_q) : SEED;
        src_alt_d  = streaming ? ~src_alt_q : 1'b1;
        exp_lfsr_d = state_q == CHECK ? lfsr_step(exp_lfsr_q) : SEED;
        exp_alt_d  = state_q == CHECK ? ~exp_alt_q : 1'b1;
    end

    always_comb begin
        busy          = state_q == FLUSH || state_q == PRIME || state_q == CHECK;
        done          = state_q == DONE;
        chain_din     = streaming ? src_bit : 1'b0;
        pass          = pass_q;
        err_count     = err_q;
        first_err_idx = first_q;
    end
endmodule
